// File: rtl/mont_domain_conv.sv
// mont_domain_conv: converts a 255-bit-modulus operand into or out of the
// Montgomery domain with R = 2^ITER. It uses one bit-serial modular step per
// clock, so latency is fixed at ITER cycles.
// Optional feature macro: MONT_FROM_DOMAIN_EN. When it is defined, dir=1
// selects A*R^-1 mod M. When it is undefined, dir is ignored and only
// conversion into the domain (A*R mod M) is built.
module mont_domain_conv #(
    parameter int ITER = 258
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] A,
    input  logic [254:0] M,
    input  logic         dir,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] R,
    output logic         err
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [254:0]  x_q, x_d;
    logic [254:0]  m_q, m_d;
    logic [254:0]  r_q, r_d;
    logic          err_q, err_d;
    logic          reject;

    logic [256:0]  dbl;
    logic [254:0]  dbl_red;
    logic [254:0]  x_step;

`ifdef MONT_FROM_DOMAIN_EN
    logic          dir_q, dir_d;
    logic [255:0]  half_sum;
    logic          unused_half_lsb;

    // Bit 0 of the halving sum is always zero because the sum is even.
    assign unused_half_lsb = half_sum[0];
`else
    logic          unused_dir;

    // Without the from-domain feature, the direction input has no effect.
    assign unused_dir = dir;
`endif

    // Compute one modular step on x.
    // Doubling: x = 2x, reduced by M when 2x >= M.
    // Halving (optional): x = x/2 if x is even, else (x+M)/2.
    // Because x < M, one conditional subtraction keeps the result reduced.
    always_comb begin
        dbl     = {1'b0, x_q, 1'b0};
        dbl_red = dbl[254:0] - m_q;
        x_step  = (dbl >= {2'b00, m_q}) ? dbl_red : dbl[254:0];
`ifdef MONT_FROM_DOMAIN_EN
        half_sum = x_q[0] ? ({1'b0, x_q} + {1'b0, m_q}) : {1'b0, x_q};
        if (dir_q) begin
            x_step = half_sum[255:1];
        end
`endif
    end

    // Compute the next state for the IDLE/RUN/DONE control and the datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        m_d     = m_q;
        r_d     = r_q;
        err_d   = err_q;
        reject  = 1'b0;
`ifdef MONT_FROM_DOMAIN_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d    = M;
                    reject = (M == '0) || (A >= {1'b0, M});
`ifdef MONT_FROM_DOMAIN_EN
                    dir_d  = dir;
                    if (dir && !M[0]) begin
                        reject = 1'b1;
                    end
`endif
                    if (reject) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        r_d     = '0;
                    end else begin
                        x_d     = A[254:0];
                        cnt_d   = CW'(ITER);
                        state_d = RUN;
                        err_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                x_d   = x_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    r_d     = x_step;
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register all state. Asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
`ifdef MONT_FROM_DOMAIN_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            m_q     <= m_d;
            r_q     <= r_d;
            err_q   <= err_d;
`ifdef MONT_FROM_DOMAIN_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign R         = {1'b0, r_q};
    assign err       = err_q;

endmodule

// File: tb/tb_mont_domain_conv.sv
// tb_mont_domain_conv: checks mont_domain_conv against an arithmetic model.
// The model uses wide multiply, shift and modulo operations.
// Build with MONT_FROM_DOMAIN_EN defined to also exercise the from-domain path.
module tb_mont_domain_conv;

    localparam int ITER = 258;

`ifdef MONT_FROM_DOMAIN_EN
    localparam bit FROM_EN = 1'b1;
`else
    localparam bit FROM_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] A;
    logic [254:0] M;
    logic         dir;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] R;
    logic         err;

    int compared   = 0;
    int mismatched = 0;
    int ncyc       = 0;

    typedef struct {
        logic [255:0] r;
        logic         e;
        int           due;
    } exp_t;

    exp_t expQ[$];

    mont_domain_conv #(.ITER(ITER)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .M        (M),
        .dir      (dir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .R        (R),
        .err      (err)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compute base^e mod m by square-and-multiply on wide integers.
    function automatic logic [599:0] modpow(input logic [599:0] base, input int e, input logic [599:0] m);
        logic [599:0] res;
        logic [599:0] b;
        res = 600'd1 % m;
        b   = base % m;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) res = (res * b) % m;
            b = (b * b) % m;
        end
        return res;
    endfunction

    // Reference model. Returns {err, R}.
    function automatic logic [256:0] model(input logic [255:0] a, input logic [254:0] m, input logic d);
        logic [599:0] t;
        logic [599:0] mw;
        logic [599:0] inv2;
        mw = 600'(m);
        if (m == '0 || a >= {1'b0, m} || (FROM_EN && d && !m[0])) begin
            return {1'b1, 256'd0};
        end
        if (FROM_EN && d) begin
            inv2 = (mw + 600'd1) >> 1;
            t    = (600'(a) * modpow(inv2, ITER, mw)) % mw;
        end else begin
            t    = (600'(a) << ITER) % mw;
        end
        return {1'b0, t[255:0]};
    endfunction

    // Compare process. On every falling edge it checks handshakes and results
    // against the queue of expected results.
    // A normal result appears ITER rising edges after the accepting edge.
    // A rejected request finishes on the accepting edge itself.
    always @(negedge clk) begin
        logic     wasEmpty;
        logic [256:0] mres;
        exp_t     ex;
        ncyc++;
        if (!rst_n) begin
            expQ.delete();
        end else begin
            wasEmpty = (expQ.size() == 0);
            checkOutput("in_ready", {255'd0, in_ready}, {255'd0, wasEmpty});
            if (wasEmpty) begin
                checkOutput("out_valid_idle", {255'd0, out_valid}, 256'd0);
            end else if (ncyc < expQ[0].due) begin
                checkOutput("out_valid_early", {255'd0, out_valid}, 256'd0);
            end else begin
                checkOutput("out_valid_due", {255'd0, out_valid}, 256'd1);
                checkOutput("R", R, expQ[0].r);
                checkOutput("err", {255'd0, err}, {255'd0, expQ[0].e});
                if (out_ready && out_valid) void'(expQ.pop_front());
            end
            if (wasEmpty && in_valid) begin
                mres  = model(A, M, dir);
                ex.r  = mres[255:0];
                ex.e  = mres[256];
                ex.due = ncyc + (mres[256] ? 1 : ITER + 1);
                expQ.push_back(ex);
            end
        end
    end

    // Issue one request. Then scramble the inputs to show they were latched.
    // Hold the result for holdCycles with stray in_valid pulses, then consume it.
    task automatic applyStimulus(input logic [255:0] a, input logic [254:0] m, input logic d, input int holdCycles);
        @(posedge clk); #1;
        A = a; M = m; dir = d; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; M = ~m; dir = ~d;
        for (int k = 0; k < ITER + 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checkOutput("result_timeout", {255'd0, out_valid}, 256'd1);
        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk); #1;
            in_valid = (k % 2 == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [256:0] pin;
    logic [255:0] ra;
    logic [254:0] rm;
    logic [255:0] wide;

    // Watchdog so that the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and random stimulus.
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; M = '0; dir = 1'b0;
        #2;
        checkOutput("reset_out_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("reset_R", R, 256'd0);
        checkOutput("reset_err", {255'd0, err}, 256'd0);

        // Hand-computed values that pin the model.
        // 2^258 mod 13 = 2^6 mod 13 = 12, and 2^-258 mod 13 = 12^-1 mod 13 = 12.
        pin = model(256'd1, 255'd13, 1'b0);
        checkOutput("pin_1_into", pin[255:0], 256'd12);
        pin = model(256'd12, 255'd13, 1'b0);
        checkOutput("pin_12_into", pin[255:0], 256'd1);
        pin = model(256'd2, 255'd13, 1'b1);
        checkOutput("pin_2_dir1", pin[255:0], 256'd11);
        pin = model(256'd12, 255'd13, 1'b1);
        checkOutput("pin_12_dir1", pin[255:0], 256'd1);
        pin = model(256'd13, 255'd13, 1'b0);
        checkOutput("pin_err", {255'd0, pin[256]}, 256'd1);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors.
        applyStimulus(256'd1, 255'd13, 1'b0, 0);
        applyStimulus(256'd12, 255'd13, 1'b1, 0);
        applyStimulus(256'd2, 255'd13, 1'b1, 1);
        applyStimulus(256'd13, 255'd13, 1'b0, 0);
        applyStimulus(256'd0, 255'd0, 1'b0, 0);
        wide = 256'd1 << 255;
        applyStimulus(wide, 255'd13, 1'b0, 0);
        applyStimulus(256'd0, 255'd13, 1'b0, 5);
        applyStimulus(256'd12, 255'd13, 1'b0, 0);
`ifdef MONT_FROM_DOMAIN_EN
        applyStimulus(256'd3, 255'd14, 1'b1, 0);
`endif

        // Reset asserted 100 cycles into RUN aborts the operation.
        @(posedge clk); #1;
        A = 256'd1; M = 255'd13; dir = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("abort_R", R, 256'd0);
        checkOutput("abort_err", {255'd0, err}, 256'd0);
        checkOutput("abort_in_ready", {255'd0, in_ready}, 256'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(256'd1, 255'd13, 1'b0, 0);

        // Back-to-back requests with in_valid and out_ready held high.
        @(posedge clk); #1;
        A = 256'd5; M = 255'd13; dir = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (2 * ITER + 8) @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < ITER + 10; k++) begin
            @(negedge clk);
            if (expQ.size() == 0) break;
        end
        checkOutput("drain_timeout", 256'(expQ.size()), 256'd0);
        @(posedge clk); #1 out_ready = 1'b0;

        // Random odd 255-bit moduli. Convert in, then convert the model result back.
        for (int t = 0; t < 3; t++) begin
            for (int w = 0; w < 8; w++) wide[w*32 +: 32] = $urandom;
            rm = wide[254:0];
            rm[254] = 1'b1;
            rm[0] = 1'b1;
            for (int w = 0; w < 8; w++) wide[w*32 +: 32] = $urandom;
            ra = wide % {1'b0, rm};
            applyStimulus(ra, rm, 1'b0, 0);
            pin = model(ra, rm, 1'b0);
            applyStimulus(pin[255:0], rm, 1'b1, 0);
`ifdef MONT_FROM_DOMAIN_EN
            pin = model(pin[255:0], rm, 1'b1);
            checkOutput("round_trip", pin[255:0], ra);
`endif
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
